hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the RV32 core, sitting beside the IF/ID and ID/EX registers.
//  A per-register countdown scoreboard tracks in-flight loads and stalls dependent ALU ops and ID-resolved branches.
//  A small FSM generates multi-cycle IF/ID flushes on control redirects, with an optional mispredict-only mode.
//  A data-memory stall freezes the whole front end.
// PARAMETERS
//  REG_AW        5  register-index width; NREG = 2**REG_AW entries, x0 never tracked
//  ALU_WAIT      1  bubbles a non-branch consumer needs after a load, with EX/MEM forwarding
//  BR_WAIT       2  bubbles a branch/jalr consumer needs after a load; branches resolve in ID; BR_WAIT >= ALU_WAIT
//  FLUSH_CYCLES  1  IF/ID flush length per redirect, 1..7
// PORTS
//  clk            in   1       core clock
//  rst            in   1       asynchronous active-high reset
//  id_valid       in   1       IF/ID holds a real instruction
//  id_op          in   7       opcode in ID
//  id_rs1/id_rs2  in   REG_AW  source indices in ID
//  id_use_rs1/2   in   1       source is actually read (e.g. jal: both 0; jalr: rs1 only)
//  id_is_load     in   1       ID instruction is a load
//  id_rd          in   REG_AW  destination index in ID
//  redirect       in   1       ID resolved taken branch, jal or jalr this cycle
//  pred_taken     in   1       IF predicted taken for this ID instruction (used only with BP_FLUSH_EN)
//  mem_stall      in   1       data memory busy; freeze pipeline
//  pc_hold        out  1       hold the PC
//  ifid_hold      out  1       hold the IF/ID register
//  idex_bubble    out  1       insert a NOP into ID/EX (control-mux select)
//  ifid_flush     out  1       zero IF/ID on the next edge
//  sb_busy        out  1       any scoreboard counter nonzero
// BEHAVIOUR
//  Reset: every counter = 0; FSM = IDLE; all outputs 0.
//  Issue: issue = id_valid & ~ifid_hold & ~mem_stall.
//   - On issue with id_is_load and id_rd != 0: cnt[id_rd] <= BR_WAIT.
//   - This overrides any older value of that counter.
//  Countdown: when ~mem_stall, every nonzero cnt decrements by 1 each cycle.
//   - The issuing write wins over the decrement for the same index.
//   - All counters hold while mem_stall is high.
//   - Counter width is $clog2(BR_WAIT+1); no wrap below 0.
//  Dependency check (combinational from ID):
//   - dep_s = id_use_s & (id_rs_s != 0) & (cnt[id_rs_s] > thr).
//   - thr = 0 if id_op is BRANCH or JALR; otherwise thr = BR_WAIT - ALU_WAIT.
//   - ld_stall = id_valid & (dep_rs1 | dep_rs2).
//  Outputs, in priority order:
//   - mem_stall: pc_hold = ifid_hold = 1; idex_bubble = 0; ifid_flush = 0.
//   - else ld_stall: pc_hold = ifid_hold = idex_bubble = 1; ifid_flush = 0. Redirect is ignored this cycle.
//   - else FSM: ifid_flush = (state == FLUSH) | redirect_q, where redirect_q = the qualified redirect below.
//  Redirect qualification:
//   - With BP_FLUSH_EN: redirect_q = redirect ^ pred_taken.
//   - Without BP_FLUSH_EN: redirect_q = redirect.
//  FSM (advances only when ~mem_stall & ~ld_stall):
//   - IDLE -> FLUSH on redirect_q; the flush counter loads FLUSH_CYCLES-1.
//   - FLUSH: counter decrements; return to IDLE when it reaches 0.
//   - FLUSH_CYCLES = 1 never enters FLUSH.
//   - A new redirect_q while in FLUSH reloads the counter. ID holds a bubble during FLUSH, so this happens only via pred_taken.
//  Boundaries:
//   - id_rd = 0 is never marked.
//   - A load to rd with a later consumer of rd under the same mem_stall: that consumer stalls until the counter clears.
//   - Back-to-back loads to the same rd restart the countdown.
//   - Asynchronous rst mid-flush or mid-stall clears everything immediately.
//  Latency: outputs are combinational from ID inputs and registered state; scoreboard effects appear one edge after issue.
// CONFIGURATION
//  BP_FLUSH_EN defined:
//   - Flush only on a mispredict: actual != predicted.
//   - A predicted-taken branch that is not taken also flushes.
//  BP_FLUSH_EN undefined:
//   - Flush on every taken redirect; pred_taken is unused.
// STRUCTURE
//  hazard_pkg:
//   - OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011.
//   - FSM state typedef {IDLE, FLUSH}.
//  Sub-module load_scoreboard:
//   - Contains the counter array, issue/decrement logic and the two read ports with per-port thresholds.
//   - Outputs dep_rs1, dep_rs2, sb_busy.
//  The top level holds the priority mux and the flush FSM.
// TESTING
//  - lw x5 issued, next cycle add x6,x5,x1 in ID -> exactly 1 cycle of pc_hold/ifid_hold/idex_bubble, then issue.
//  - lw x5 then beq x5,x0 in ID -> 2 stall cycles (BR_WAIT=2); with one independent op between -> 1 stall.
//  - lw x5, then mem_stall high 3 cycles, then add x6,x5 -> counter frozen; 1 bubble after mem_stall drops; no idex_bubble while frozen.
//  - lw x0 then add x1,x0,x0 -> no stall; jal with id_use_rs* = 0 after lw x5 -> no stall.
//  - redirect=1 with FLUSH_CYCLES=3 -> ifid_flush high 3 consecutive cycles; rst asserted in 2nd cycle -> flush 0 at once, state IDLE.
//  - BP_FLUSH_EN: redirect=1, pred_taken=1 -> no flush; redirect=0, pred_taken=1 -> 1-cycle flush; without macro -> only the first flushes.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcodes, flush FSM state type and helpers for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_e;

   // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 7.
   localparam int FLUSH_CNT_W = 3;

   // Consumers that read their operands in ID and so cannot use EX/MEM forwarding.
   function automatic logic resolves_in_id(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Per-register countdown of in-flight loads, with two ID read ports and
// opcode-dependent thresholds for branch versus ALU consumers.
module load_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int ALU_WAIT = 1,
   parameter int BR_WAIT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic              freeze,
   input  logic              is_load,
   input  logic [REG_AW-1:0] rd,
   input  logic [6:0]        op,
   input  logic [REG_AW-1:0] rs1,
   input  logic              use_rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              use_rs2,
   output logic              dep_rs1,
   output logic              dep_rs2,
   output logic              sb_busy
);

   localparam int NREG = 2 ** REG_AW;
   localparam int CW   = (BR_WAIT < 1) ? 1 : $clog2(BR_WAIT + 1);

   localparam logic [CW-1:0] BR_CNT  = CW'(BR_WAIT);
   localparam logic [CW-1:0] ALU_THR = CW'(BR_WAIT - ALU_WAIT);

   logic [CW-1:0] cnt [NREG];
   logic [CW-1:0] thr;

   // Entry 0 is only ever reset, so x0 reads as permanently clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      end else if (!freeze) begin
         for (int i = 1; i < NREG; i++) begin
            if (issue && is_load && (rd == REG_AW'(i))) begin
               cnt[i] <= BR_CNT;
            end else if (cnt[i] != '0) begin
               cnt[i] <= cnt[i] - CW'(1);
            end
         end
      end
   end

   always_comb begin
      thr = resolves_in_id(op) ? '0 : ALU_THR;
   end

   assign dep_rs1 = use_rs1 & (rs1 != '0) & (cnt[rs1] > thr);
   assign dep_rs2 = use_rs2 & (rs2 != '0) & (cnt[rs2] > thr);

   always_comb begin
      sb_busy = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         sb_busy = sb_busy | (cnt[i] != '0);
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: load-use stalls, memory freeze and redirect flushes.
// Optional macro BP_FLUSH_EN restricts flushes to mispredicted control transfers.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int ALU_WAIT     = 1,
   parameter int BR_WAIT      = 2,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [6:0]        id_op,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_is_load,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              redirect,
   input  logic              pred_taken,
   input  logic              mem_stall,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              sb_busy
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   logic dep_rs1;
   logic dep_rs2;
   logic ld_stall;
   logic issue;
   logic advance;
   logic redirect_q;

   flush_state_e           state, state_n;
   logic [FLUSH_CNT_W-1:0] fcnt, fcnt_n;

   // id_valid qualifies every ID field; an instruction issues on the first
   // cycle it is valid while neither the memory freeze nor the IF/ID hold is up.
   assign issue    = id_valid & ~ifid_hold & ~mem_stall;
   assign ld_stall = id_valid & (dep_rs1 | dep_rs2);
   assign advance  = ~mem_stall & ~ld_stall;

`ifdef BP_FLUSH_EN
   assign redirect_q = redirect ^ pred_taken;
`else
   logic pred_taken_unused;
   assign pred_taken_unused = pred_taken;
   assign redirect_q        = redirect;
`endif

   load_scoreboard #(
      .REG_AW   (REG_AW),
      .ALU_WAIT (ALU_WAIT),
      .BR_WAIT  (BR_WAIT)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .issue   (issue),
      .freeze  (mem_stall),
      .is_load (id_is_load),
      .rd      (id_rd),
      .op      (id_op),
      .rs1     (id_rs1),
      .use_rs1 (id_use_rs1),
      .rs2     (id_rs2),
      .use_rs2 (id_use_rs2),
      .dep_rs1 (dep_rs1),
      .dep_rs2 (dep_rs2),
      .sb_busy (sb_busy)
   );

   always_comb begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (mem_stall) begin
         pc_hold   = 1'b1;
         ifid_hold = 1'b1;
      end else if (ld_stall) begin
         // A stalled branch has not really resolved, so its redirect is dropped.
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         ifid_flush = (state == FLUSH) | redirect_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         fcnt  <= '0;
      end else begin
         state <= state_n;
         fcnt  <= fcnt_n;
      end
   end

   // The redirect cycle itself is the first flush; FLUSH covers the remaining ones.
   always_comb begin
      state_n = state;
      fcnt_n  = fcnt;
      if (advance) begin
         case (state)
            IDLE: begin
               if (redirect_q && (FLUSH_CYCLES > 1)) begin
                  state_n = FLUSH;
                  fcnt_n  = FLUSH_LOAD;
               end
            end
            FLUSH: begin
               if (redirect_q) begin
                  fcnt_n = FLUSH_LOAD;
               end else if (fcnt <= FLUSH_CNT_W'(1)) begin
                  state_n = IDLE;
                  fcnt_n  = '0;
               end else begin
                  fcnt_n = fcnt - FLUSH_CNT_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               fcnt_n  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (BR_WAIT=2, ALU_WAIT=1, FLUSH_CYCLES=3).
module tb_hazard_scoreboard_unit;
   import hazard_pkg::*;

   localparam int         REG_AW = 5;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [6:0]        id_op;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              id_is_load;
   logic [REG_AW-1:0] id_rd;
   logic              redirect;
   logic              pred_taken;
   logic              mem_stall;
   logic              pc_hold;
   logic              ifid_hold;
   logic              idex_bubble;
   logic              ifid_flush;
   logic              sb_busy;

   int n_total = 0;
   int n_pass  = 0;

`ifdef BP_FLUSH_EN
   localparam logic BP = 1'b1;
`else
   localparam logic BP = 1'b0;
`endif

   hazard_scoreboard_unit #(
      .REG_AW       (REG_AW),
      .ALU_WAIT     (1),
      .BR_WAIT      (2),
      .FLUSH_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_op       (id_op),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_is_load  (id_is_load),
      .id_rd       (id_rd),
      .redirect    (redirect),
      .pred_taken  (pred_taken),
      .mem_stall   (mem_stall),
      .pc_hold     (pc_hold),
      .ifid_hold   (ifid_hold),
      .idex_bubble (idex_bubble),
      .ifid_flush  (ifid_flush),
      .sb_busy     (sb_busy)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [6:0] op,
                        input int rs1, input logic u1, input int rs2, input logic u2,
                        input logic ld, input int rd);
      id_valid   = v;
      id_op      = op;
      id_rs1     = REG_AW'(rs1);
      id_use_rs1 = u1;
      id_rs2     = REG_AW'(rs2);
      id_use_rs2 = u2;
      id_is_load = ld;
      id_rd      = REG_AW'(rd);
   endtask

   task automatic idle();
      drive(1'b0, 7'd0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
   endtask

   task automatic chk(input string tag, input logic e_pc, input logic e_ifid,
                      input logic e_bub, input logic e_fl);
      chk1({tag, ".pc_hold"},     pc_hold,     e_pc);
      chk1({tag, ".ifid_hold"},   ifid_hold,   e_ifid);
      chk1({tag, ".idex_bubble"}, idex_bubble, e_bub);
      chk1({tag, ".ifid_flush"},  ifid_flush,  e_fl);
   endtask

   task automatic nc();
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      redirect   = 1'b0;
      pred_taken = 1'b0;
      mem_stall  = 1'b0;
      idle();

      // Reset state
      nc(); #1;
      chk("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("reset.sb_busy", sb_busy, 1'b0);
      rst = 1'b0;

      // lw x5; add x6,x5,x1 -> one bubble
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t1_lw", 0, 0, 0, 0);
      nc(); drive(1, OP_ALU, 5, 1, 1, 1, 0, 6); #1 chk("t1_add_stall", 1, 1, 1, 0);
      chk1("t1_busy", sb_busy, 1'b1);
      nc(); #1 chk("t1_add_issue", 0, 0, 0, 0);
      nc(); idle(); #1 chk1("t1_clear", sb_busy, 1'b0);

      // lw x5; beq x5,x0 -> two bubbles
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t2_lw", 0, 0, 0, 0);
      nc(); drive(1, OP_BRANCH, 5, 1, 0, 1, 0, 0); #1 chk("t2_beq_s1", 1, 1, 1, 0);
      nc(); #1 chk("t2_beq_s2", 1, 1, 1, 0);
      nc(); #1 chk("t2_beq_issue", 0, 0, 0, 0);

      // lw x5; add x7,x1,x2; beq x5 -> one bubble
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t2b_lw", 0, 0, 0, 0);
      nc(); drive(1, OP_ALU, 1, 1, 2, 1, 0, 7); #1 chk("t2b_indep", 0, 0, 0, 0);
      nc(); drive(1, OP_BRANCH, 5, 1, 0, 1, 0, 0); #1 chk("t2b_beq_s1", 1, 1, 1, 0);
      nc(); #1 chk("t2b_beq_issue", 0, 0, 0, 0);

      // Back-to-back loads to x5 restart the countdown
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t3_lw_a", 0, 0, 0, 0);
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t3_lw_b", 0, 0, 0, 0);
      nc(); drive(1, OP_BRANCH, 5, 1, 0, 1, 0, 0); #1 chk("t3_beq_s1", 1, 1, 1, 0);
      nc(); #1 chk("t3_beq_s2", 1, 1, 1, 0);
      nc(); #1 chk("t3_beq_issue", 0, 0, 0, 0);

      // lw x5; mem_stall 3 cycles with add x6,x5 waiting -> frozen, then one bubble
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t4_lw", 0, 0, 0, 0);
      nc(); mem_stall = 1'b1; drive(1, OP_ALU, 5, 1, 1, 1, 0, 6); #1 chk("t4_ms1", 1, 1, 0, 0);
      nc(); #1 chk("t4_ms2", 1, 1, 0, 0);
      nc(); #1 chk("t4_ms3", 1, 1, 0, 0);
      chk1("t4_frozen_busy", sb_busy, 1'b1);
      nc(); mem_stall = 1'b0; #1 chk("t4_after_ms", 1, 1, 1, 0);
      nc(); #1 chk("t4_issue", 0, 0, 0, 0);
      nc(); idle(); #1 chk1("t4_clear", sb_busy, 1'b0);

      // lw x0 never marks; add x1,x0,x0 does not stall
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 0); #1 chk("t5_lw_x0", 0, 0, 0, 0);
      nc(); drive(1, OP_ALU, 0, 1, 0, 1, 0, 1); #1 chk("t5_add_x0", 0, 0, 0, 0);
      chk1("t5_x0_busy", sb_busy, 1'b0);
      // jal with no source reads after lw x5
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t5_lw", 0, 0, 0, 0);
      nc(); drive(1, OP_JAL, 5, 0, 5, 0, 0, 1); #1 chk("t5_jal", 0, 0, 0, 0);
      nc(); idle(); nc(); #1 chk1("t5_clear", sb_busy, 1'b0);

      // Redirect ignored under load stall, then a 3-cycle flush
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t6_lw", 0, 0, 0, 0);
      nc(); redirect = 1'b1; drive(1, OP_BRANCH, 5, 1, 0, 1, 0, 0); #1 chk("t6_stall_a", 1, 1, 1, 0);
      nc(); #1 chk("t6_stall_b", 1, 1, 1, 0);
      nc(); #1 chk("t6_flush1", 0, 0, 0, 1);
      nc(); redirect = 1'b0; idle(); #1 chk("t6_flush2", 0, 0, 0, 1);
      nc(); #1 chk("t6_flush3", 0, 0, 0, 1);
      nc(); #1 chk("t6_done", 0, 0, 0, 0);

      // Async reset in the 2nd flush cycle
      nc(); redirect = 1'b1; drive(1, OP_JAL, 0, 0, 0, 0, 0, 1); #1 chk("t7_flush1", 0, 0, 0, 1);
      nc(); redirect = 1'b0; idle(); #1 chk("t7_flush2", 0, 0, 0, 1);
      #1 rst = 1'b1;
      #1 chk("t7_rst_now", 0, 0, 0, 0);
      nc(); rst = 1'b0; #1 chk("t7_idle_after", 0, 0, 0, 0);

      // Async reset during a load stall clears the scoreboard
      nc(); drive(1, OP_LOAD, 1, 1, 0, 0, 1, 5); #1 chk("t8_lw", 0, 0, 0, 0);
      nc(); drive(1, OP_ALU, 5, 1, 1, 1, 0, 6); #1 chk("t8_stall", 1, 1, 1, 0);
      #1 rst = 1'b1;
      #1 chk("t8_rst_now", 0, 0, 0, 0);
      chk1("t8_rst_busy", sb_busy, 1'b0);
      nc(); rst = 1'b0; #1 chk("t8_add_free", 0, 0, 0, 0);

      // redirect=1, pred_taken=1: flush only without BP_FLUSH_EN
      nc(); redirect = 1'b1; pred_taken = 1'b1; drive(1, OP_BRANCH, 1, 0, 2, 0, 0, 0);
      #1 chk("t9_rt_pt_f1", 0, 0, 0, ~BP);
      nc(); redirect = 1'b0; pred_taken = 1'b0; idle(); #1 chk("t9_rt_pt_f2", 0, 0, 0, ~BP);
      nc(); #1 chk("t9_rt_pt_f3", 0, 0, 0, ~BP);
      nc(); #1 chk("t9_rt_pt_done", 0, 0, 0, 0);

      // redirect=0, pred_taken=1: flush only with BP_FLUSH_EN
      nc(); pred_taken = 1'b1; drive(1, OP_BRANCH, 1, 0, 2, 0, 0, 0);
      #1 chk("t10_nt_pt_f1", 0, 0, 0, BP);
      nc(); pred_taken = 1'b0; idle(); #1 chk("t10_nt_pt_f2", 0, 0, 0, BP);
      nc(); #1 chk("t10_nt_pt_f3", 0, 0, 0, BP);
      nc(); #1 chk("t10_nt_pt_done", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
